pi_ctrl: RTL
============

# pi_ctrl

Fixed-point PI controller that sits directly upstream of the shared 16x16 signed sequential multiplier. It consumes it as a service, issuing two multiplies per control step: Kp·err and Ki·integral. It then combines the products, rescales and saturates them, and presents a 16-bit command to the motor-drive stage. It owns the integrator state and the multiplier handshake.

## Interface
- FRAC, 8: fractional bits of kp/ki (Q(15-FRAC).FRAC); products are arithmetic-shifted right by FRAC.
- WAIT_TO, 4: max cycles to wait for mul_busy to rise after an issue before aborting.
- clk  in  1  clock.
- rst  in  1  reset rst, synchronous, active-high; clock clk.
- start  in  1  request one control step; sampled only in IDLE.
- clear  in  1  zero the integrator; sampled only in IDLE.
- err  in  16  signed error sample, latched when start is accepted.
- kp, ki  in  16  signed gains, latched when start is accepted.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  one-cycle pulse when u is updated.
- u  out  16  signed saturated command; holds its value between steps.
- err_flag  out  1  one-cycle pulse on multiplier timeout.
- mul_en  out  1  one-cycle start pulse to the multiplier.
- mul_a, mul_b  out  16  multiplier operands; held stable from issue until capture.
- mul_busy  in  1  multiplier busy.
- mul_r  in  32  signed product; valid once mul_busy has returned low.

## Operation
- State register; integ (16-bit signed); p_reg and i_reg (32-bit); latched err, kp, ki; timeout counter (3 bits minimum).
- IDLE:
  - clear=1 sets integ to 0; start is ignored that cycle (clear wins).
  - Otherwise start=1 latches err, kp, ki and goes to LOAD.
- LOAD: integ <= sat16(integ + err), using a 17-bit signed sum clamped to [-32768, 32767].
- ISSUE_P: mul_en=1, mul_a=err, mul_b=kp; clear the timeout counter; go to WAIT_P_HI.
- WAIT_P_HI:
  - mul_busy=1 → WAIT_P_LO.
  - Otherwise increment the counter; when it reaches WAIT_TO → ABORT.
- WAIT_P_LO: when mul_busy=0, p_reg <= mul_r and go to ISSUE_I.
- ISSUE_I, WAIT_I_HI, WAIT_I_LO: same sequence with mul_a=integ (the updated value) and mul_b=ki; capture into i_reg.
- SUM:
  - s = sext33(p_reg) + sext33(i_reg).
  - t = s >>> FRAC (arithmetic shift, rounds toward −inf).
  - u <= sat16(t).
  - Go to DONE.
- DONE: out_valid=1; go to IDLE.
- ABORT:
  - err_flag=1; go to IDLE.
  - u unchanged, no out_valid.
  - integ keeps its LOAD update.
- mul_en is high only in ISSUE_*. mul_a and mul_b are driven from registered values in every state; their value in IDLE is don't-care.
- mul_busy must hold 0 in WAIT_*_LO only after it has been seen high in WAIT_*_HI.

## Timing
- Reset values:
  - State IDLE; all of busy, out_valid, err_flag, mul_en = 0.
  - u, integ, p_reg, i_reg = 0; mul_a = mul_b = 0.
- start accepted at edge N puts the block in LOAD during cycle N+1, and busy rises in the same cycle.
- Latency from start to out_valid is 6 + 2·Tm cycles, where Tm = cycles from a mul_en pulse to the first cycle with mul_busy low again.
  - The shared multiplier gives Tm = 49 (busy 48 cycles), so latency is 104 cycles.
- start or clear while busy=1 is ignored; neither is queued.
- rst mid-operation:
  - Returns to IDLE next edge with all reset values.
  - mul_en drops immediately.
  - A multiplier still running is left to finish; its result is discarded.
- Back-to-back: start can be accepted in the cycle after DONE (IDLE).

## Test plan
- FRAC=8; kp=0x0100, ki=0x0080, err=100, from reset → integ=100, p=25600, i=12800, u=150, out_valid pulses once at cycle 104.
- Repeat start with err=100 → integ=200, u=200; then clear, then err=100 → u=150.
- kp=0x7FFF, ki=0, err=0x7FFF → p=0x3FFF0001, u=32767. kp=0x7FFF, err=0x8000 → u=−32768.
- kp=0x0100, ki=0, err=−300 → u=−300. kp=0x0001, err=−1 → u=−1 (floor shift).
- Integrator saturation: three steps with err=0x7FFF, ki=0 → integ stays 32767 after the first step and never wraps.
- Multiplier stub holds mul_busy=0 → err_flag pulses 1+WAIT_TO cycles after ISSUE_P; busy falls, u is unchanged. Assert rst in WAIT_P_LO → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/pi_ctrl.sv
// Fixed-point PI controller that drives a shared 16x16 signed sequential multiplier.
// Latency: start to out_valid is 6 + 2*Tm cycles, counting the start cycle as cycle 1; Tm is mul_en to first mul_busy-low cycle.
// Backpressure: start/clear are taken only in IDLE and are dropped, not queued, while busy is high.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, clear    step request / integrator clear (sampled only in IDLE, clear wins)
//   err, kp, ki     signed error and gains (Q(15-FRAC).FRAC gains), latched on start
//   busy            high in every state except IDLE
//   out_valid       one-cycle pulse when u is updated
//   u               signed saturated command, held between steps
//   err_flag        one-cycle pulse when the multiplier never raises mul_busy
//   mul_en/a/b      multiplier start pulse and operands (operands registered)
//   mul_busy, mul_r multiplier status and product (product valid once busy falls)
module pi_ctrl #(
  parameter int FRAC    = 8,
  parameter int WAIT_TO = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               clear,
  input  logic signed [15:0] err,
  input  logic signed [15:0] kp,
  input  logic signed [15:0] ki,
  output logic               busy,
  output logic               out_valid,
  output logic signed [15:0] u,
  output logic               err_flag,
  output logic               mul_en,
  output logic signed [15:0] mul_a,
  output logic signed [15:0] mul_b,
  input  logic               mul_busy,
  input  logic signed [31:0] mul_r
);

  // Timeout counter is at least 3 bits wide, wider if WAIT_TO needs it.
  localparam int CW = ($clog2(WAIT_TO + 1) < 3) ? 3 : $clog2(WAIT_TO + 1);
  localparam logic [CW-1:0] TO_LIM = CW'(WAIT_TO);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_LOAD      = 4'd1;
  localparam logic [3:0] S_ISSUE_P   = 4'd2;
  localparam logic [3:0] S_WAIT_P_HI = 4'd3;
  localparam logic [3:0] S_WAIT_P_LO = 4'd4;
  localparam logic [3:0] S_ISSUE_I   = 4'd5;
  localparam logic [3:0] S_WAIT_I_HI = 4'd6;
  localparam logic [3:0] S_WAIT_I_LO = 4'd7;
  localparam logic [3:0] S_SUM       = 4'd8;
  localparam logic [3:0] S_DONE      = 4'd9;
  localparam logic [3:0] S_ABORT     = 4'd10;

  logic [3:0]         state;
  logic signed [15:0] integ;
  logic signed [31:0] p_reg;
  logic signed [31:0] i_reg;
  logic signed [15:0] err_q;
  logic signed [15:0] kp_q;
  logic signed [15:0] ki_q;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_inc;

  logic signed [16:0] integ_sum;
  logic signed [32:0] sum_s;
  logic signed [32:0] sum_t;

  function automatic logic signed [15:0] sat17(input logic signed [16:0] v);
    if (v[16:15] == {2{v[16]}}) return v[15:0];
    else if (v[16])             return 16'sh8000;
    else                        return 16'sh7FFF;
  endfunction

  function automatic logic signed [15:0] sat33(input logic signed [32:0] v);
    if (v[32:15] == {18{v[32]}}) return v[15:0];
    else if (v[32])              return 16'sh8000;
    else                         return 16'sh7FFF;
  endfunction

  // 17-bit sum cannot overflow, so clamping it gives a non-wrapping integrator.
  assign integ_sum = {integ[15], integ} + {err_q[15], err_q};
  // 33-bit sum of the two products, then floor-rescale by the gain fraction.
  assign sum_s     = {p_reg[31], p_reg} + {i_reg[31], i_reg};
  assign sum_t     = sum_s >>> FRAC;
  assign cnt_inc   = cnt + CW'(1);

  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);
  assign err_flag  = (state == S_ABORT);
  // Gated by rst so a reset in an issue cycle never launches a multiply.
  assign mul_en    = !rst && ((state == S_ISSUE_P) || (state == S_ISSUE_I));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      integ <= '0;
      p_reg <= '0;
      i_reg <= '0;
      err_q <= '0;
      kp_q  <= '0;
      ki_q  <= '0;
      cnt   <= '0;
      u     <= '0;
      mul_a <= '0;
      mul_b <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clear) begin
            integ <= '0;
          end else if (start) begin
            err_q <= err;
            kp_q  <= kp;
            ki_q  <= ki;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          integ <= sat17(integ_sum);
          // Operands are set up one cycle early so they are valid during the issue pulse.
          mul_a <= err_q;
          mul_b <= kp_q;
          state <= S_ISSUE_P;
        end
        S_ISSUE_P: begin
          cnt   <= '0;
          state <= S_WAIT_P_HI;
        end
        S_WAIT_P_HI: begin
          if (mul_busy) begin
            state <= S_WAIT_P_LO;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == TO_LIM) state <= S_ABORT;
          end
        end
        S_WAIT_P_LO: begin
          if (!mul_busy) begin
            p_reg <= mul_r;
            // integ already holds the LOAD update here.
            mul_a <= integ;
            mul_b <= ki_q;
            state <= S_ISSUE_I;
          end
        end
        S_ISSUE_I: begin
          cnt   <= '0;
          state <= S_WAIT_I_HI;
        end
        S_WAIT_I_HI: begin
          if (mul_busy) begin
            state <= S_WAIT_I_LO;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == TO_LIM) state <= S_ABORT;
          end
        end
        S_WAIT_I_LO: begin
          if (!mul_busy) begin
            i_reg <= mul_r;
            state <= S_SUM;
          end
        end
        S_SUM: begin
          u     <= sat33(sum_t);
          state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        S_ABORT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
